mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- M-stage data-memory access controller.
- Consumes the forwarded store data `M_GRF_RD_f` and the M-stage address/op.
- Aligns store data and generates byte enables, then runs a req/ack handshake to the data bus (DM or bridge).
- Stalls the pipeline until the access completes; returns sign/zero-extended load data for the M/W register and flags alignment faults and bus timeouts.

Parameters:
- TIMEOUT_CYC, 16, max cycles waiting for bus_ack before aborting with bus_err.
- CNT_W, 5, width of the timeout counter; must hold TIMEOUT_CYC.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset.
- M_valid  input  1  M stage holds a real instruction.
- M_flush  input  1  exception/interrupt flush of M stage.
- M_memop  input  4  access type (MEM_NONE, SW, SH, SB, LW, LH, LHU, LB, LBU).
- M_addr  input  32  byte address from ALU.
- M_GRF_RD_f  input  32  forwarded rt value (store data).
- bus_req  output  1  request strobe.
- bus_we  output  1  1 = write.
- bus_addr  output  32  word-aligned address ({addr[31:2],2'b00}).
- bus_byteen  output  4  byte enables.
- bus_wdata  output  32  lane-aligned store data.
- bus_ack  input  1  bus completion, one cycle.
- bus_rdata  input  32  read data, valid with bus_ack.
- stall  output  1  freeze F/D/E/M, bubble into W.
- M_ld_data  output  32  extended load result.
- M_ld_valid  output  1  M_ld_data valid this cycle.
- M_exc  output  1  alignment fault or bus_err.
- M_exc_code  output  5  4 = AdEL, 5 = AdES, 7 = bus timeout (DBE).

Behaviour:
- Reset: state IDLE; bus_req, bus_we, bus_byteen, bus_addr, bus_wdata, M_ld_data, M_ld_valid, M_exc, M_exc_code, counter all 0; stall 0.
- Misaligned access: SW/LW with addr[1:0]!=0, or SH/LH/LHU with addr[0]!=0.
  - No bus access and no stall.
  - M_exc=1 combinationally that cycle; code AdEL for loads, AdES for stores.
- FSM states: IDLE, REQ, DONE.
- IDLE, accepting a request:
  - Condition: M_valid && memop!=NONE && aligned && !M_flush.
  - Latch bus_addr/we/byteen/wdata; go REQ; stall=1 combinationally in this same cycle.
  - Otherwise stay IDLE with stall=0.
- REQ:
  - bus_req=1 and stall=1; outputs held stable.
  - On bus_ack: if load, register the extended bus_rdata into M_ld_data; go DONE.
  - Counter increments each REQ cycle without ack. When it reaches TIMEOUT_CYC: go DONE, set M_exc=1, code 7, drop bus_req.
- DONE:
  - stall=0; the pipeline advances.
  - M_ld_valid=1 for loads (0 if bus_err or if a flush was latched).
  - Next state IDLE; counter cleared.
  - M_ld_data holds until the next load completes.
- Latency: request in cycle 0, bus_req from cycle 1, ack in cycle k, DONE at k+1. Minimum 3 cycles for a zero-wait bus (ack in cycle 1).
- Store alignment:
  - SB: byteen = 4'b0001 << addr[1:0]; wdata = the byte replicated ×4.
  - SH: byteen = addr[1] ? 4'b1100 : 4'b0011; wdata = the half replicated ×2.
  - SW: byteen = 4'hF.
- Loads: bus_we=0, byteen=4'hF; the byte/half lane is selected by addr[1:0] and then extended.
  - LB/LH sign-extend; LBU/LHU zero-extend.
- M_flush:
  - In IDLE: suppresses the request.
  - In REQ: the transaction cannot be retracted. It completes normally, but the flush is latched and M_ld_valid is suppressed in DONE.
- bus_ack outside REQ is ignored.
- Async reset mid-transaction: returns to IDLE immediately; bus_req drops asynchronously.

Decomposition:
- Package mem_pkg holds:
  - memop encodings (MEM_NONE=0, SW, SH, SB, LW, LH, LHU, LB, LBU);
  - exception codes EXC_ADEL=4, EXC_ADES=5, EXC_DBE=7;
  - FSM state encodings.
- Sub-module load_ext: combinational lane select plus extension (addr[1:0], memop, rdata → data).

Test Plan:
- SB, addr 0x0000_1003, data 0x0000_00A5, ack 2 cycles after req:
  - bus_byteen=4'b1000, bus_wdata=0xA5A5A5A5, bus_addr=0x1000;
  - stall high for 4 cycles, then DONE, M_exc=0.
- LH, addr 0x2002, rdata 0x8001_1234, zero-wait ack: M_ld_data=0xFFFF8001 with M_ld_valid=1 in DONE. Repeat with LHU: 0x00008001.
- LW, addr 0x3001: M_exc=1, code 4, bus_req never asserted, stall=0. SH, addr 0x3001: code 5.
- SW with bus_ack never asserted, TIMEOUT_CYC=16:
  - bus_req high exactly 16 cycles;
  - DONE with M_exc=1, code 7; then IDLE.
- LB in REQ, M_flush pulsed, ack 3 cycles later: transaction completes, M_ld_valid=0 in DONE.
- reset asserted (low) during REQ: bus_req=0 and stall=0 immediately; after release a new SW proceeds normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared encodings for the M-stage data-memory access path:
// memop codes, exception codes, controller states and access-type helpers.
package mem_pkg;

  typedef enum logic [3:0] {
    MEM_NONE = 4'd0,
    MEM_SW   = 4'd1,
    MEM_SH   = 4'd2,
    MEM_SB   = 4'd3,
    MEM_LW   = 4'd4,
    MEM_LH   = 4'd5,
    MEM_LHU  = 4'd6,
    MEM_LB   = 4'd7,
    MEM_LBU  = 4'd8
  } mem_op_e;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;
  localparam logic [4:0] EXC_ADES = 5'd5;
  localparam logic [4:0] EXC_DBE  = 5'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DONE = 2'd2
  } mac_state_e;

  function automatic logic is_load(input mem_op_e op);
    case (op)
      MEM_LW, MEM_LH, MEM_LHU, MEM_LB, MEM_LBU: return 1'b1;
      default:                                  return 1'b0;
    endcase
  endfunction

  function automatic logic is_store(input mem_op_e op);
    case (op)
      MEM_SW, MEM_SH, MEM_SB: return 1'b1;
      default:                return 1'b0;
    endcase
  endfunction

  // Word accesses need addr[1:0]==0, halfword accesses need addr[0]==0.
  function automatic logic misaligned(input mem_op_e op, input logic [1:0] lo);
    case (op)
      MEM_SW, MEM_LW:          return lo != 2'b00;
      MEM_SH, MEM_LH, MEM_LHU: return lo[0];
      default:                 return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_ctrl_load_ext.sv
// Load-data lane select and sign/zero extension for the M-stage load path.
module load_ext
  import mem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  mem_op_e     memop,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    data = rdata;
    case (memop)
      MEM_LB:  data = {{24{byte_sel[7]}}, byte_sel};
      MEM_LBU: data = {24'd0, byte_sel};
      MEM_LH:  data = {{16{half_sel[15]}}, half_sel};
      MEM_LHU: data = {16'd0, half_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// M-stage data-memory access controller: store alignment, req/ack bus
// handshake with timeout, pipeline stall and extended load return.
module mem_access_ctrl
  import mem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 16,
  parameter int unsigned CNT_W       = 5
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        M_valid,
  input  logic        M_flush,
  input  logic [3:0]  M_memop,
  input  logic [31:0] M_addr,
  input  logic [31:0] M_GRF_RD_f,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_byteen,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata,
  output logic        stall,
  output logic [31:0] M_ld_data,
  output logic        M_ld_valid,
  output logic        M_exc,
  output logic [4:0]  M_exc_code
);

  localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT_CYC);

  mac_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  logic [31:0]       addr_q, addr_d;
  logic              we_q, we_d;
  logic [3:0]        byteen_q, byteen_d;
  logic [31:0]       wdata_q, wdata_d;
  mem_op_e           op_q, op_d;
  logic [1:0]        lane_q, lane_d;
  logic [31:0]       ld_data_q, ld_data_d;
  logic              err_q, err_d;
  logic              flush_q, flush_d;

  mem_op_e           op_in;
  logic              live_op;
  logic              bad_align;
  logic              accept;
  logic [31:0]       ext_data;

  load_ext u_load_ext (
    .addr_lo (lane_q),
    .memop   (op_q),
    .rdata   (bus_rdata),
    .data    (ext_data)
  );

  assign bus_addr   = addr_q;
  assign bus_we     = we_q;
  assign bus_byteen = byteen_q;
  assign bus_wdata  = wdata_q;
  assign M_ld_data  = ld_data_q;

  always_comb begin
    op_in     = mem_op_e'(M_memop);
    live_op   = M_valid && !M_flush && (op_in != MEM_NONE);
    bad_align = misaligned(op_in, M_addr[1:0]);
    accept    = live_op && !bad_align;
    cnt_inc   = cnt_q + 1'b1;

    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    we_d       = we_q;
    byteen_d   = byteen_q;
    wdata_d    = wdata_q;
    op_d       = op_q;
    lane_d     = lane_q;
    ld_data_d  = ld_data_q;
    err_d      = err_q;
    flush_d    = flush_q;

    bus_req    = 1'b0;
    stall      = 1'b0;
    M_ld_valid = 1'b0;
    M_exc      = 1'b0;
    M_exc_code = EXC_NONE;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = ST_REQ;
          stall   = 1'b1;
          addr_d  = {M_addr[31:2], 2'b00};
          we_d    = is_store(op_in);
          op_d    = op_in;
          lane_d  = M_addr[1:0];
          cnt_d   = '0;
          err_d   = 1'b0;
          flush_d = 1'b0;
          case (op_in)
            MEM_SB: begin
              byteen_d = 4'b0001 << M_addr[1:0];
              wdata_d  = {4{M_GRF_RD_f[7:0]}};
            end
            MEM_SH: begin
              byteen_d = M_addr[1] ? 4'b1100 : 4'b0011;
              wdata_d  = {2{M_GRF_RD_f[15:0]}};
            end
            MEM_SW: begin
              byteen_d = 4'hF;
              wdata_d  = M_GRF_RD_f;
            end
            default: begin
              byteen_d = 4'hF;
              wdata_d  = '0;
            end
          endcase
        end else if (live_op && bad_align) begin
          M_exc      = 1'b1;
          M_exc_code = is_load(op_in) ? EXC_ADEL : EXC_ADES;
        end
      end

      ST_REQ: begin
        bus_req = 1'b1;
        stall   = 1'b1;
        // A flush cannot retract an issued access; remember it to squash the result.
        if (M_flush) flush_d = 1'b1;
        if (bus_ack) begin
          if (is_load(op_q)) ld_data_d = ext_data;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_inc;
          if (cnt_inc == TO_CNT) begin
            state_d = ST_DONE;
            err_d   = 1'b1;
          end
        end
      end

      ST_DONE: begin
        state_d    = ST_IDLE;
        cnt_d      = '0;
        M_ld_valid = is_load(op_q) && !err_q && !flush_q;
        if (err_q) begin
          M_exc      = 1'b1;
          M_exc_code = EXC_DBE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      addr_q    <= '0;
      we_q      <= 1'b0;
      byteen_q  <= '0;
      wdata_q   <= '0;
      op_q      <= MEM_NONE;
      lane_q    <= '0;
      ld_data_q <= '0;
      err_q     <= 1'b0;
      flush_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      we_q      <= we_d;
      byteen_q  <= byteen_d;
      wdata_q   <= wdata_d;
      op_q      <= op_d;
      lane_q    <= lane_d;
      ld_data_q <= ld_data_d;
      err_q     <= err_d;
      flush_q   <= flush_d;
    end
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: stimulus pushes expected bus requests,
// load results and exceptions; a negedge monitor pops and compares them.
module tb_mem_access_ctrl;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        M_valid = 1'b0;
  logic        M_flush = 1'b0;
  logic [3:0]  M_memop = 4'd0;
  logic [31:0] M_addr = '0;
  logic [31:0] M_GRF_RD_f = '0;
  logic        bus_req, bus_we, stall, M_ld_valid, M_exc;
  logic [31:0] bus_addr, bus_wdata, M_ld_data;
  logic [3:0]  bus_byteen;
  logic [4:0]  M_exc_code;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  int ack_delay = -1;
  int n_checks = 0;
  int n_pass = 0;

  typedef struct {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    bit          has_wd;
  } bus_exp_t;

  bus_exp_t    bus_q[$];
  logic [31:0] ld_q[$];
  logic [4:0]  exc_q[$];

  mem_access_ctrl #(.TIMEOUT_CYC(16), .CNT_W(5)) dut (
    .clk        (clk),
    .reset      (reset),
    .M_valid    (M_valid),
    .M_flush    (M_flush),
    .M_memop    (M_memop),
    .M_addr     (M_addr),
    .M_GRF_RD_f (M_GRF_RD_f),
    .bus_req    (bus_req),
    .bus_we     (bus_we),
    .bus_addr   (bus_addr),
    .bus_byteen (bus_byteen),
    .bus_wdata  (bus_wdata),
    .bus_ack    (bus_ack),
    .bus_rdata  (bus_rdata),
    .stall      (stall),
    .M_ld_data  (M_ld_data),
    .M_ld_valid (M_ld_valid),
    .M_exc      (M_exc),
    .M_exc_code (M_exc_code)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic exp_bus(input logic we, input logic [3:0] be, input logic [31:0] addr,
                         input logic [31:0] wd, input bit has_wd);
    bus_exp_t e;
    e.we = we; e.be = be; e.addr = addr; e.wdata = wd; e.has_wd = has_wd;
    bus_q.push_back(e);
  endtask

  // Bus responder: acks in the ack_delay-th cycle of bus_req (0 = zero-wait), -1 never.
  initial begin
    int req_idx;
    req_idx = 0;
    forever begin
      @(posedge clk); #1;
      if (bus_req) begin
        bus_ack = (ack_delay >= 0) && (req_idx == ack_delay);
        req_idx++;
      end else begin
        bus_ack = 1'b0;
        req_idx = 0;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    logic prev_req;
    bus_exp_t e;
    logic [31:0] ed;
    logic [4:0] ec;
    prev_req = 1'b0;
    forever begin
      @(negedge clk);
      if (bus_req && !prev_req) begin
        if (bus_q.size() == 0) begin
          n_checks++;
          $display("FAIL bus_unexpected: got request addr %h, expected none", bus_addr);
        end else begin
          e = bus_q.pop_front();
          check("bus_we_be_addr", {bus_we, bus_byteen, bus_addr}, {e.we, e.be, e.addr});
          if (e.has_wd) check("bus_wdata", bus_wdata, e.wdata);
        end
      end
      prev_req = bus_req;
      if (M_ld_valid) begin
        if (ld_q.size() == 0) begin
          n_checks++;
          $display("FAIL ld_unexpected: got M_ld_valid data %h, expected none", M_ld_data);
        end else begin
          ed = ld_q.pop_front();
          check("ld_data", M_ld_data, ed);
        end
      end
      if (M_exc) begin
        if (exc_q.size() == 0) begin
          n_checks++;
          $display("FAIL exc_unexpected: got code %0d, expected none", M_exc_code);
        end else begin
          ec = exc_q.pop_front();
          check("exc_code", M_exc_code, ec);
        end
      end
    end
  end

  // Issue one M-stage access and count stall / bus_req cycles until stall releases.
  task automatic do_txn(input string tag, input logic [3:0] op, input logic [31:0] addr,
                        input logic [31:0] wd, input logic [31:0] rd, input int dly,
                        input int flush_cyc, input int exp_stall, input int exp_req);
    int cyc, n_stall, n_req;
    bit done;
    @(posedge clk); #1;
    ack_delay = dly; bus_rdata = rd;
    M_valid = 1'b1; M_memop = op; M_addr = addr; M_GRF_RD_f = wd;
    cyc = 0; n_stall = 0; n_req = 0; done = 1'b0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      if (stall) n_stall++;
      if (bus_req) n_req++;
      if (!stall) done = 1'b1;
      @(posedge clk); #1;
      M_valid = 1'b0; M_memop = MEM_NONE;
      cyc++;
      M_flush = (cyc == flush_cyc);
    end
    M_flush = 1'b0;
    if (!done) begin
      n_checks++;
      $display("FAIL %s_timeout: stall still high after %0d cycles, expected release", tag, cyc);
    end
    check({tag, "_stall_cycles"}, n_stall, exp_stall);
    check({tag, "_req_cycles"}, n_req, exp_req);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, expected $finish");
    $fatal(1);
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    check("rst_ctrl", {bus_req, stall, M_ld_valid, M_exc, M_exc_code, bus_we}, '0);
    check("rst_bus", {bus_byteen, bus_addr, bus_wdata}, '0);
    check("rst_ld_data", M_ld_data, '0);
    reset = 1'b1;

    exp_bus(1'b1, 4'b1000, 32'h0000_1000, 32'hA5A5_A5A5, 1'b1);
    do_txn("sb", MEM_SB, 32'h0000_1003, 32'h0000_00A5, '0, 2, -1, 4, 3);

    exp_bus(1'b0, 4'hF, 32'h0000_2000, '0, 1'b0);
    ld_q.push_back(32'hFFFF_8001);
    do_txn("lh", MEM_LH, 32'h0000_2002, '0, 32'h8001_1234, 0, -1, 2, 1);

    exp_bus(1'b0, 4'hF, 32'h0000_2000, '0, 1'b0);
    ld_q.push_back(32'h0000_8001);
    do_txn("lhu", MEM_LHU, 32'h0000_2002, '0, 32'h8001_1234, 0, -1, 2, 1);

    exc_q.push_back(EXC_ADEL);
    do_txn("lw_mis", MEM_LW, 32'h0000_3001, '0, '0, 0, -1, 0, 0);

    exc_q.push_back(EXC_ADES);
    do_txn("sh_mis", MEM_SH, 32'h0000_3001, 32'h1111_2222, '0, 0, -1, 0, 0);

    exp_bus(1'b1, 4'hF, 32'h0000_6000, 32'hDEAD_BEEF, 1'b1);
    exc_q.push_back(EXC_DBE);
    do_txn("sw_to", MEM_SW, 32'h0000_6000, 32'hDEAD_BEEF, '0, -1, -1, 17, 16);
    check("ld_data_hold", M_ld_data, 32'h0000_8001);

    exp_bus(1'b0, 4'hF, 32'h0000_4000, '0, 1'b0);
    ld_q.push_back(32'hFFFF_FF80);
    do_txn("lb", MEM_LB, 32'h0000_4001, '0, 32'h1234_80FF, 1, -1, 3, 2);

    exp_bus(1'b0, 4'hF, 32'h0000_4000, '0, 1'b0);
    ld_q.push_back(32'h0000_00C3);
    do_txn("lbu", MEM_LBU, 32'h0000_4003, '0, 32'hC300_0000, 0, -1, 2, 1);

    exp_bus(1'b1, 4'b1100, 32'h0000_5000, 32'hABCD_ABCD, 1'b1);
    do_txn("sh", MEM_SH, 32'h0000_5002, 32'h1234_ABCD, '0, 0, -1, 2, 1);

    exp_bus(1'b0, 4'hF, 32'h0000_7000, '0, 1'b0);
    do_txn("lb_flush", MEM_LB, 32'h0000_7000, '0, 32'h0000_0055, 3, 1, 5, 4);

    // Asynchronous reset in the middle of a request.
    exp_bus(1'b1, 4'hF, 32'h0000_8000, 32'hCAFE_F00D, 1'b1);
    @(posedge clk); #1;
    ack_delay = -1;
    M_valid = 1'b1; M_memop = MEM_SW; M_addr = 32'h0000_8000; M_GRF_RD_f = 32'hCAFE_F00D;
    @(posedge clk); #1;
    M_valid = 1'b0; M_memop = MEM_NONE;
    @(posedge clk); #1;
    check("mid_req_active", bus_req, 1'b1);
    reset = 1'b0;
    #1;
    check("async_rst_req", bus_req, 1'b0);
    check("async_rst_stall", stall, 1'b0);
    @(posedge clk); #1;
    reset = 1'b1;

    exp_bus(1'b1, 4'hF, 32'h0000_8004, 32'h0102_0304, 1'b1);
    do_txn("sw_post_rst", MEM_SW, 32'h0000_8004, 32'h0102_0304, '0, 0, -1, 2, 1);

    repeat (3) @(posedge clk);
    check("bus_q_drained", bus_q.size(), 0);
    check("ld_q_drained", ld_q.size(), 0);
    check("exc_q_drained", exc_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
